// File: rtl/riscv_pkg.sv
// Shared opcode constants, FSM state encoding and ALUOp encodings for the multicycle controller.
package riscv_pkg;

  localparam int unsigned OP_W  = 7;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned ST_W  = 3;

  localparam logic [OP_W-1:0] OP_R    = 7'b0110011;
  localparam logic [OP_W-1:0] OP_I    = 7'b0010011;
  localparam logic [OP_W-1:0] OP_LW   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_SW   = 7'b0100011;
  localparam logic [OP_W-1:0] OP_BR   = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL  = 7'b1101111;
  localparam logic [OP_W-1:0] OP_JALR = 7'b1100111;
  localparam logic [OP_W-1:0] OP_HALT = 7'b1111111;

  typedef enum logic [ST_W-1:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALTED = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD = 2'b00,  // LW / SW / JALR address add
    ALUOP_BR  = 2'b01,  // branch compare
    ALUOP_RI  = 2'b10   // R/I-type, funct fields decide
  } aluop_t;

endpackage

// File: rtl/opcode_decode.sv
// Combinational opcode classification; anything outside the recognised set is flagged illegal.
module opcode_decode
  import riscv_pkg::*;
(
  input  logic [OP_W-1:0] op,
  output logic            is_r,
  output logic            is_i,
  output logic            is_lw,
  output logic            is_sw,
  output logic            is_br,
  output logic            is_jal,
  output logic            is_jalr,
  output logic            is_halt,
  output logic            is_illegal
);

  assign is_r    = (op == OP_R);
  assign is_i    = (op == OP_I);
  assign is_lw   = (op == OP_LW);
  assign is_sw   = (op == OP_SW);
  assign is_br   = (op == OP_BR);
  assign is_jal  = (op == OP_JAL);
  assign is_jalr = (op == OP_JALR);
  assign is_halt = (op == OP_HALT);

  assign is_illegal = ~(is_r | is_i | is_lw | is_sw | is_br | is_jal | is_jalr | is_halt);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V control FSM: fetch/decode/exec/mem/wb sequencing, strobes, retired-instruction count.
module multicycle_ctrl
  import riscv_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [OP_W-1:0]   Opcode,
  input  logic              IMemReady,
  input  logic              DMemReady,
  output logic              IMemReq,
  output logic              IRWrite,
  output logic              PCWrite,
  output logic              ALUSrc,
  output logic              MemtoReg,
  output logic              RegWrite,
  output logic              MemRead,
  output logic              MemWrite,
  output logic              Branch,
  output logic              Jump,
  output logic              JumpReg,
  output logic [1:0]        ALUOp,
  output logic              Halt,
  output logic              IllegalOp,
  output logic [ST_W-1:0]   State,
  output logic [CNT_W-1:0]  InstrCount
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [OP_W-1:0]    r_op_q;
  logic               r_illegal;
  logic [CNT_W-1:0]   r_instr_count;

  logic [OP_W-1:0]    w_dec_op;
  logic               w_is_r;
  logic               w_is_i;
  logic               w_is_lw;
  logic               w_is_sw;
  logic               w_is_br;
  logic               w_is_jal;
  logic               w_is_jalr;
  logic               w_is_halt;
  logic               w_is_illegal;

  // DECODE classifies the live opcode; later states only ever see the latched copy
  assign w_dec_op = (r_state == S_DECODE) ? Opcode : r_op_q;

  opcode_decode u_opcode_decode (
    .op         (w_dec_op),
    .is_r       (w_is_r),
    .is_i       (w_is_i),
    .is_lw      (w_is_lw),
    .is_sw      (w_is_sw),
    .is_br      (w_is_br),
    .is_jal     (w_is_jal),
    .is_jalr    (w_is_jalr),
    .is_halt    (w_is_halt),
    .is_illegal (w_is_illegal)
  );

  // State register, opcode latch, sticky illegal flag and retired-instruction counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_op_q        <= '0;
      r_illegal     <= 1'b0;
      r_instr_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_DECODE) begin
        r_op_q <= Opcode;
        if (w_is_illegal) begin
          r_illegal <= 1'b1;
        end
      end
      if (PCWrite) begin
        r_instr_count <= r_instr_count + CNT_W'(1);
      end
    end
  end

  // Next-state and strobe decode from current state and latched opcode
  always_comb begin
    w_state_nxt = r_state;
    IMemReq     = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    ALUSrc      = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    Branch      = 1'b0;
    Jump        = 1'b0;
    JumpReg     = 1'b0;
    ALUOp       = ALUOP_ADD;

    unique case (r_state)
      S_IDLE: begin
        w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        IMemReq = 1'b1;
        if (IMemReady) begin
          IRWrite     = 1'b1;
          w_state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        if (w_is_halt || w_is_illegal) begin
          w_state_nxt = S_HALTED;
        end else begin
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        ALUSrc = w_is_lw | w_is_sw | w_is_i | w_is_jalr;
        if (w_is_br) begin
          ALUOp = ALUOP_BR;
        end else if (w_is_r || w_is_i) begin
          ALUOp = ALUOP_RI;
        end
        if (w_is_br) begin
          Branch      = 1'b1;
          PCWrite     = 1'b1;
          w_state_nxt = S_FETCH;
        end else if (w_is_lw || w_is_sw) begin
          w_state_nxt = S_MEM;
        end else begin
          w_state_nxt = S_WB;
        end
      end
      S_MEM: begin
        MemRead  = w_is_lw;
        MemWrite = w_is_sw;
        if (DMemReady) begin
          if (w_is_sw) begin
            PCWrite     = 1'b1;
            w_state_nxt = S_FETCH;
          end else begin
            w_state_nxt = S_WB;
          end
        end
      end
      S_WB: begin
        RegWrite    = 1'b1;
        PCWrite     = 1'b1;
        MemtoReg    = w_is_lw;
        Jump        = w_is_jal | w_is_jalr;
        JumpReg     = w_is_jalr;
        w_state_nxt = S_FETCH;
      end
      S_HALTED: begin
        w_state_nxt = S_HALTED;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign Halt       = (r_state == S_HALTED);
  assign IllegalOp  = r_illegal;
  assign State      = ST_W'(r_state);
  assign InstrCount = r_instr_count;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expected state/strobes queued as stimulus is driven, popped at sample time.
module tb_multicycle_ctrl;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  Opcode;
  logic        IMemReady;
  logic        DMemReady;
  logic        IMemReq, IRWrite, PCWrite, ALUSrc, MemtoReg, RegWrite;
  logic        MemRead, MemWrite, Branch, Jump, JumpReg, Halt, IllegalOp;
  logic [1:0]  ALUOp;
  logic [2:0]  State;
  logic [31:0] InstrCount;

  multicycle_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .Opcode     (Opcode),
    .IMemReady  (IMemReady),
    .DMemReady  (DMemReady),
    .IMemReq    (IMemReq),
    .IRWrite    (IRWrite),
    .PCWrite    (PCWrite),
    .ALUSrc     (ALUSrc),
    .MemtoReg   (MemtoReg),
    .RegWrite   (RegWrite),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .Branch     (Branch),
    .Jump       (Jump),
    .JumpReg    (JumpReg),
    .ALUOp      (ALUOp),
    .Halt       (Halt),
    .IllegalOp  (IllegalOp),
    .State      (State),
    .InstrCount (InstrCount)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_F = 3'd1, ST_D = 3'd2, ST_E = 3'd3,
                         ST_M = 3'd4, ST_WB = 3'd5, ST_H = 3'd6;

  // Strobe vector bit masks: {IMemReq,IRWrite,PCWrite,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,Jump,JumpReg,ALUOp[1:0],Halt,IllegalOp}
  localparam logic [14:0] NONE = 15'h0000, IMREQ = 15'h4000, IRW = 15'h2000, PCW = 15'h1000,
                          ASRC = 15'h0800, M2R = 15'h0400, RW = 15'h0200, MR = 15'h0100,
                          MW = 15'h0080, BRN = 15'h0040, JMP = 15'h0020, JR = 15'h0010,
                          AOP_RI = 15'h0008, AOP_BR = 15'h0004, HLT = 15'h0002, ILL = 15'h0001;

  typedef struct packed {
    logic [2:0]  st;
    logic [14:0] sig;
  } exp_t;

  exp_t  sb_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  string tag = "init";

  wire [14:0] obs_sig = {IMemReq, IRWrite, PCWrite, ALUSrc, MemtoReg, RegWrite, MemRead,
                         MemWrite, Branch, Jump, JumpReg, ALUOp, Halt, IllegalOp};

  task automatic push_exp(input logic [2:0] st, input logic [14:0] s);
    exp_t e;
    e.st  = st;
    e.sig = s;
    sb_q.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    exp_t o;
    o.st  = State;
    o.sig = obs_sig;
    if (sb_q.size() == 0) e = '1;
    else                  e = sb_q.pop_front();
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed state=%0d strobes=%h, expected state=%0d strobes=%h",
             tag, o.st, o.sig, e.st, e.sig);
    end
  endtask

  task automatic check_cnt(input logic [31:0] exp_cnt);
    n_cmp++;
    assert (InstrCount === exp_cnt) else begin
      n_err++;
      $error("FAIL %s_count: observed InstrCount=%h, expected %h", tag, InstrCount, exp_cnt);
    end
  endtask

  // One clock: queue the expected output, drive ready inputs, sample after they settle
  task automatic exp_step(input logic [2:0] st, input logic [14:0] s,
                          input logic imr, input logic dmr);
    push_exp(st, s);
    @(negedge clk);
    IMemReady = imr;
    DMemReady = dmr;
    #1;
    check_out();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    IMemReady = 1'b0;
    DMemReady = 1'b0;
    #1;
    push_exp(ST_IDLE, NONE);
    check_out();
    check_cnt(32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    push_exp(ST_IDLE, NONE);
    check_out();
  endtask

  task automatic run_r();
    Opcode = OP_R;
    exp_step(ST_F,  IMREQ | IRW, 1'b1, 1'b1);
    exp_step(ST_D,  NONE,        1'b1, 1'b1);
    exp_step(ST_E,  AOP_RI,      1'b1, 1'b1);
    exp_step(ST_WB, RW | PCW,    1'b1, 1'b1);
  endtask

  initial begin
    reset     = 1'b1;
    IMemReady = 1'b0;
    DMemReady = 1'b0;
    Opcode    = '0;

    // R-type with readies tied high, then stall in FETCH
    tag = "rtype";
    do_reset();
    run_r();
    tag = "rtype_wait";
    exp_step(ST_F, IMREQ, 1'b0, 1'b1);
    check_cnt(32'd1);
    exp_step(ST_F, IMREQ, 1'b0, 1'b0);

    // LW with three data-memory wait cycles
    tag = "lw";
    do_reset();
    Opcode = OP_LW;
    exp_step(ST_F,  IMREQ | IRW,    1'b1, 1'b0);
    exp_step(ST_D,  NONE,           1'b1, 1'b1);
    exp_step(ST_E,  ASRC,           1'b0, 1'b1);
    exp_step(ST_M,  MR,             1'b0, 1'b0);
    exp_step(ST_M,  MR,             1'b0, 1'b0);
    exp_step(ST_M,  MR,             1'b0, 1'b0);
    exp_step(ST_M,  MR,             1'b0, 1'b1);
    exp_step(ST_WB, RW | PCW | M2R, 1'b0, 1'b0);
    exp_step(ST_F,  IMREQ,          1'b0, 1'b0);
    check_cnt(32'd1);

    // BR followed by JALR
    tag = "br_jalr";
    do_reset();
    Opcode = OP_BR;
    exp_step(ST_F, IMREQ | IRW,        1'b1, 1'b1);
    exp_step(ST_D, NONE,               1'b1, 1'b1);
    exp_step(ST_E, BRN | PCW | AOP_BR, 1'b1, 1'b1);
    Opcode = OP_JALR;
    exp_step(ST_F,  IMREQ | IRW,         1'b1, 1'b1);
    exp_step(ST_D,  NONE,                1'b1, 1'b1);
    exp_step(ST_E,  ASRC,                1'b1, 1'b1);
    exp_step(ST_WB, RW | PCW | JMP | JR, 1'b1, 1'b1);
    exp_step(ST_F,  IMREQ,               1'b0, 1'b0);
    check_cnt(32'd2);

    // HALT opcode after one retired instruction; readies ignored, count frozen
    tag = "halt";
    do_reset();
    run_r();
    Opcode = OP_HALT;
    exp_step(ST_F, IMREQ | IRW, 1'b1, 1'b1);
    exp_step(ST_D, NONE,        1'b1, 1'b1);
    exp_step(ST_H, HLT,         1'b1, 1'b1);
    exp_step(ST_H, HLT,         1'b0, 1'b1);
    exp_step(ST_H, HLT,         1'b1, 1'b0);
    check_cnt(32'd1);

    // Unrecognised opcode after fresh reset
    tag = "illegal";
    do_reset();
    Opcode = 7'h00;
    exp_step(ST_F, IMREQ | IRW, 1'b1, 1'b1);
    exp_step(ST_D, NONE,        1'b1, 1'b1);
    exp_step(ST_H, HLT | ILL,   1'b1, 1'b1);
    exp_step(ST_H, HLT | ILL,   1'b1, 1'b1);
    check_cnt(32'd0);

    // Asynchronous reset in the middle of a stalled SW
    tag = "rst_mem";
    do_reset();
    run_r();
    Opcode = OP_SW;
    exp_step(ST_F, IMREQ | IRW, 1'b1, 1'b0);
    exp_step(ST_D, NONE,        1'b0, 1'b0);
    exp_step(ST_E, ASRC,        1'b0, 1'b0);
    exp_step(ST_M, MW,          1'b0, 1'b0);
    exp_step(ST_M, MW,          1'b0, 1'b0);
    check_cnt(32'd1);
    reset = 1'b1;
    #1;
    push_exp(ST_IDLE, NONE);
    check_out();
    check_cnt(32'd0);

    // Counter wrap on a retired SW
    tag = "wrap";
    do_reset();
    Opcode = OP_SW;
    exp_step(ST_F, IMREQ, 1'b0, 1'b0);
    force dut.r_instr_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_instr_count;
    #1;
    check_cnt(32'hFFFF_FFFF);
    exp_step(ST_F, IMREQ | IRW, 1'b1, 1'b0);
    exp_step(ST_D, NONE,        1'b0, 1'b0);
    exp_step(ST_E, ASRC,        1'b0, 1'b0);
    exp_step(ST_M, MW | PCW,    1'b0, 1'b1);
    exp_step(ST_F, IMREQ,       1'b0, 1'b0);
    check_cnt(32'd0);

    tag = "drain";
    n_cmp++;
    assert (sb_q.size() == 0) else begin
      n_err++;
      $error("FAIL %s: observed %0d leftover entries, expected 0", tag, sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: Opcode  in  7  instr[6:0] from instruction register; valid from DECODE onward.
REQ-004 SHALL have ports: IMemReady  in  1  instruction memory has data for the current IMemReq.
REQ-005 SHALL have ports: DMemReady  in  1  data memory completed the current MemRead/MemWrite.
REQ-006 SHALL have ports: IMemReq  out  1  instruction fetch request.
REQ-007 SHALL have ports: IRWrite  out  1  load instruction register.
REQ-008 SHALL have ports: PCWrite  out  1  update PC (PC+4, branch or jump target, selected by datapath).
REQ-009 SHALL have ports: ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump, JumpReg  out  1 each  datapath strobes, same meaning as single-cycle control.
REQ-010 SHALL have ports: ALUOp  out  2  00 LW/SW/JALR, 01 branch, 10 R/I-type.
REQ-011 SHALL have ports: Halt  out  1  sticky halted flag.
REQ-012 SHALL have ports: IllegalOp  out  1  sticky, set on unrecognised opcode.
REQ-013 SHALL have ports: State  out  3  current state encoding, debug.
REQ-014 SHALL have ports: InstrCount  out  32  retired-instruction counter.

Function
REQ-015 SHALL implement states IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALTED=6.
REQ-016 SHALL go IDLE -> FETCH unconditionally; all outputs in IDLE are 0.
REQ-017 SHALL assert IMemReq in FETCH; on IMemReady=1, SHALL assert IRWrite that cycle and go DECODE; otherwise SHALL stay in FETCH (unbounded wait).
REQ-018 SHALL latch Opcode into internal op_q in DECODE; EXEC/MEM/WB SHALL use only op_q.
REQ-019 DECODE: 1111111 -> HALTED; unrecognised opcode -> HALTED with IllegalOp set; otherwise -> EXEC.
REQ-020 Recognised opcodes: R 0110011, I 0010011, LW 0000011, SW 0100011, BR 1100011, JAL 1101111, JALR 1100111.
REQ-021 EXEC SHALL drive ALUSrc=1 for LW/SW/I/JALR and ALUOp per REQ-010.
REQ-022 BR in EXEC SHALL assert Branch=1 and PCWrite=1 and go FETCH.
REQ-023 LW/SW SHALL go EXEC -> MEM; R/I/JAL/JALR SHALL go EXEC -> WB.
REQ-024 MEM SHALL hold MemRead (LW) or MemWrite (SW) asserted until DMemReady=1.
REQ-025 On DMemReady=1 in MEM, SW SHALL assert PCWrite and go FETCH, and LW SHALL go WB.
REQ-026 WB SHALL assert RegWrite=1 and PCWrite=1, MemtoReg=1 for LW, Jump=1 for JAL/JALR, and JumpReg=1 for JALR, then go FETCH.
REQ-027 Every strobe SHALL be a single-cycle pulse except the held MemRead/MemWrite/IMemReq.
REQ-028 Latency (no wait states): BR 3 cycles; R/I/JAL/JALR/SW 4; LW 5.
REQ-029 InstrCount SHALL increment by 1 on every cycle PCWrite=1 and wrap 0xFFFFFFFF -> 0.
REQ-030 HALTED SHALL hold Halt=1, all other strobes 0 and InstrCount frozen until reset; IMemReady/DMemReady are ignored.
REQ-031 Ready inputs arriving outside their waiting state SHALL be ignored.

Reset
REQ-032 Reset assertion SHALL at any time, including mid-MEM, immediately force state IDLE, all outputs 0, InstrCount=0, Halt=0, IllegalOp=0, op_q=0.
REQ-033 The first FETCH SHALL occur in the second cycle after reset deasserts.

Structure
REQ-034 Opcode constants, the state enum and ALUOp encodings SHALL live in shared package riscv_pkg.
REQ-035 Combinational opcode classification SHALL be sub-module opcode_decode (op -> is_r/is_i/is_lw/is_sw/is_br/is_jal/is_jalr/is_halt/is_illegal).
REQ-036 State and counter SHALL be in one always_ff; strobes SHALL be decoded combinationally from state and op_q.

Verification
REQ-037 Bench: reset, IMemReady=1 and DMemReady=1 tied high, Opcode=0110011 -> states 1,2,3,5,1; RegWrite and PCWrite pulse in WB; InstrCount=1.
REQ-038 Bench: LW with DMemReady low for 3 MEM cycles -> MemRead high 4 cycles, then WB with MemtoReg=1; total 8 cycles FETCH-to-FETCH.
REQ-039 Bench: BR then JALR -> BR PCWrite in EXEC with Branch=1, ALUOp=01; JALR WB has Jump=1, JumpReg=1, ALUSrc=1 in EXEC; InstrCount=2.
REQ-040 Bench: Opcode=1111111, then Opcode=0000000 after a fresh reset -> HALTED with Halt=1 and IllegalOp=0 the first time, IllegalOp=1 the second time; InstrCount unchanged while halted.
REQ-041 Bench: reset asserted during MEM with MemWrite=1 -> MemWrite=0 in the same cycle, State=0, InstrCount=0.
REQ-042 Bench: InstrCount preloaded near wrap via force to 0xFFFFFFFF, one SW retired -> InstrCount=0.
